// File: rtl/cmp_search_ctrl.sv
// Binary-search controller for an external magnitude comparator.
// It drives a probe value, reads back the gt/lt/eq flags and narrows the
// [lo, hi] window until the hidden target is found or the window is empty.
// lo/hi carry one extra bit so that lo may step past hi without wrapping.
module cmp_search_ctrl #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  output logic [W-1:0] probe_o,
  input  logic         cmp_gt_i,
  input  logic         cmp_lt_i,
  input  logic         cmp_eq_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         found_o,
  output logic         err_o,
  output logic [W-1:0] result_o
);

  localparam logic [W:0]   HI_INIT   = {1'b0, {W{1'b1}}};
  localparam logic [W:0]   ONE_EXT   = {{W{1'b0}}, 1'b1};
  localparam logic [W-1:0] PROBE_MAX = {W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_EVAL  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e       state_q;
  logic [W:0]   lo_q, hi_q;
  logic [W:0]   lo_d, hi_d;
  logic [W-1:0] probe_q, result_q;
  logic [W-1:0] probe_d;
  logic         busy_q, done_q, found_q, err_q;
  logic [W:0]   probe_ext;
  logic         hit, bad, stop, eval_end;

  assign probe_ext = {1'b0, probe_q};
  // Window midpoint; lo <= hi <= 2^W-1 here, so the top bit is always zero.
  assign probe_d   = W'(lo_q + ((hi_q - lo_q) >> 1));

  // Decode the comparator flags into the next window and the end condition.
  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    hit  = 1'b0;
    bad  = 1'b0;
    stop = 1'b0;
    unique case ({cmp_gt_i, cmp_lt_i, cmp_eq_i})
      3'b001: hit = 1'b1;
      3'b100: begin
        if (probe_q == PROBE_MAX) stop = 1'b1;
        else                      lo_d = probe_ext + ONE_EXT;
      end
      3'b010: begin
        if (probe_q == '0) stop = 1'b1;
        else               hi_d = probe_ext - ONE_EXT;
      end
      default: bad = 1'b1;
    endcase
    eval_end = hit | bad | stop | (lo_d > hi_d);
  end

  // Search sequencer with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= HI_INIT;
      probe_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            lo_q     <= '0;
            hi_q     <= HI_INIT;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_PROBE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_PROBE: begin
          probe_q <= probe_d;
          state_q <= S_EVAL;
        end
        S_EVAL: begin
          lo_q <= lo_d;
          hi_q <= hi_d;
          if (eval_end) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            found_q <= hit;
            err_q   <= bad;
            if (hit) result_q <= probe_q;
            state_q <= S_DONE;
          end else begin
            state_q <= S_PROBE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign probe_o  = probe_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign found_o  = found_q;
  assign err_o    = err_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed bench for cmp_search_ctrl (W=4) with a behavioural comparator.
module tb_cmp_search_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] probe;
  logic       cmp_gt, cmp_lt, cmp_eq;
  logic       busy, done, found, err;
  logic [3:0] result;

  int         target;
  int         mode;      // 0 = real comparator, 1 = no flags, 2 = gt and lt
  int         n_vec;
  int         n_err;
  int         probes[8];
  int         nprobe;
  int         cyc;

  cmp_search_ctrl #(.W(4)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .probe_o  (probe),
    .cmp_gt_i (cmp_gt),
    .cmp_lt_i (cmp_lt),
    .cmp_eq_i (cmp_eq),
    .busy_o   (busy),
    .done_o   (done),
    .found_o  (found),
    .err_o    (err),
    .result_o (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cmp_gt = 1'b0;
    cmp_lt = 1'b0;
    cmp_eq = 1'b0;
    case (mode)
      0: begin
        cmp_gt = (target > int'(probe));
        cmp_lt = (target < int'(probe));
        cmp_eq = (target == int'(probe));
      end
      2: begin
        cmp_gt = 1'b1;
        cmp_lt = 1'b1;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a search from a negedge; records odd-cycle probes until done.
  task automatic do_search(input int t, input string tag);
    target = t;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    check({tag, " busy@start"}, 32'(busy), 1);
    check({tag, " cleared"}, {26'd0, err, found, result}, 0);
    nprobe = 0;
    cyc    = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((k % 2) == 1 && nprobe < 8) begin
        probes[nprobe] = int'(probe);
        nprobe++;
      end
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic check_seq(input string tag, input int n, input logic [19:0] seq);
    check({tag, " nprobe"}, 32'(nprobe), 32'(n));
    check({tag, " done cycle"}, 32'(cyc), 32'(2 * n));
    for (int i = 0; i < n && i < nprobe; i++)
      check($sformatf("%s probe%0d", tag, i), 32'(probes[i]), 32'(seq[4*i +: 4]));
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    mode   = 0;
    target = 0;
    start  = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("reset outputs", {22'd0, busy, done, found, err, probe, result}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset", {22'd0, busy, done, found, err, probe, result}, 0);

    // T=7: single probe
    do_search(7, "T7");
    check_seq("T7", 1, 20'h00007);
    check("T7 found", 32'(found), 1);
    check("T7 result", 32'(result), 7);
    @(negedge clk);
    check("T7 done pulse width", 32'(done), 0);
    check("T7 idle busy", 32'(busy), 0);
    check("T7 found held", 32'(found), 1);
    check("T7 probe held", 32'(probe), 7);

    // T=0: lower boundary
    do_search(0, "T0");
    check_seq("T0", 4, 20'h00137);
    check("T0 found", 32'(found), 1);
    check("T0 result", 32'(result), 0);
    @(negedge clk);

    // T=15: upper boundary
    do_search(15, "T15");
    check_seq("T15", 5, 20'hFEDB7);
    check("T15 found", 32'(found), 1);
    check("T15 result", 32'(result), 15);
    @(negedge clk);

    // No flags set
    mode = 1;
    do_search(5, "NOFLAG");
    check("NOFLAG done cycle", 32'(cyc), 2);
    check("NOFLAG err", 32'(err), 1);
    check("NOFLAG found", 32'(found), 0);
    check("NOFLAG result", 32'(result), 0);
    @(negedge clk);
    check("NOFLAG err held", 32'(err), 1);

    // gt and lt both set
    mode = 2;
    do_search(5, "GTLT");
    check("GTLT done cycle", 32'(cyc), 2);
    check("GTLT err", 32'(err), 1);
    check("GTLT found", 32'(found), 0);
    @(negedge clk);
    mode = 0;

    // Reset during the second probe
    target = 9;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    check("RST first probe", 32'(probe), 7);
    @(negedge clk);
    @(negedge clk);
    check("RST second probe", 32'(probe), 11);
    rst_n = 1'b0;
    #1;
    check("RST outputs cleared", {22'd0, busy, done, found, err, probe, result}, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("RST no done", 32'(done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("RST idle", {22'd0, busy, done, found, err, probe, result}, 0);
    do_search(9, "T9");
    check_seq("T9", 3, 20'h009B7);
    check("T9 result", 32'(result), 9);
    check("T9 found", 32'(found), 1);
    @(negedge clk);

    // start held through DONE: back-to-back restart
    target = 7;
    start  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("B2B first done", 32'(done), 1);
    check("B2B first result", 32'(result), 7);
    @(negedge clk);
    start = 1'b0;
    check("B2B restart busy", 32'(busy), 1);
    check("B2B restart done low", 32'(done), 0);
    check("B2B found cleared", 32'(found), 0);
    check("B2B result cleared", 32'(result), 0);
    @(negedge clk);
    check("B2B probe", 32'(probe), 7);
    @(negedge clk);
    check("B2B second done", 32'(done), 1);
    check("B2B second result", {27'd0, found, result}, 32'h17);
    @(negedge clk);

    // Exhaustive targets
    for (int t = 0; t < 16; t++) begin
      do_search(t, $sformatf("EX%0d", t));
      check($sformatf("EX%0d found", t), 32'(found), 1);
      check($sformatf("EX%0d result", t), 32'(result), 32'(t));
      check($sformatf("EX%0d probes<=5", t), 32'(nprobe >= 1 && nprobe <= 5), 1);
      check($sformatf("EX%0d timing", t), 32'(cyc), 32'(2 * nprobe));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
